// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions.
//   rx_state_t : receive state machine encoding
//   calc_div() : clocks per oversample tick, round(clk / (baud * os)), min 1.
//                Shared by uart_rx, the packet handler TX side and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic int unsigned calc_div(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned os
    );
        longint unsigned den;
        longint unsigned q;
        den = baud * os;
        q   = (clk_hz + den / 2) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen -- divides the system clock down to BAUD_RATE*OVERSAMPLE.
//   clk     : system clock
//   rst_n   : async active-low reset
//   i_clear : sync restart; the next tick comes a full DIV clocks later
//   o_tick  : one-cycle pulse every DIV clocks
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int          CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clear || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with oversampled majority-vote bit decisions
// and a one-entry valid/ready output holding register.
//   clk, rst_n      : system clock, async active-low reset
//   rx_serial       : asynchronous serial line, idle high
//   rx_byte         : received byte, stable while valid and not transferred
//   rx_byte_valid   : rx_byte holds an unconsumed byte
//   rx_byte_ready   : downstream accepts (transfer on valid & ready)
//   frame_error     : one-cycle pulse when the stop bit votes low
//   overrun_error   : one-cycle pulse when a completed byte is dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    input  logic       rx_byte_ready,
    output logic       frame_error,
    output logic       overrun_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    // r_tick_cnt holds the number of ticks already seen in the current bit,
    // so the tick taken while it equals OVERSAMPLE/2-2 is tick OVERSAMPLE/2-1.
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    logic [1:0]    r_sync;
    rx_state_t     r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_samp;
    logic [7:0]    r_shift;
    logic          r_commit;
    logic          r_frame_err;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_ovr;

    logic w_rx;
    logic w_tick;
    logic w_start;
    logic w_maj;
    logic w_xfer;

    // Synchronizer resets high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx_serial};
    end

    assign w_rx    = r_sync[1];
    assign w_start = (r_state == RX_IDLE) && !w_rx;
    // Third sample is taken live from the line, the first two are stored.
    assign w_maj   = (r_samp[1] & r_samp[0]) | (r_samp[1] & w_rx) | (r_samp[0] & w_rx);
    assign w_xfer  = r_valid && rx_byte_ready;

    // Restart the divider on the start edge so sample points are edge-aligned.
    uart_baud_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RX_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_samp      <= '0;
            r_shift     <= '0;
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx) begin
                        r_state    <= RX_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_rx) r_state <= RX_IDLE;
                end
                default: begin
                    if (w_tick) begin
                        r_tick_cnt <= (r_tick_cnt == T_LAST) ? '0 : r_tick_cnt + 1'b1;
                        if (r_tick_cnt == T_S0 || r_tick_cnt == T_S1)
                            r_samp <= {r_samp[0], w_rx};
                        if (r_tick_cnt == T_S2) begin
                            case (r_state)
                                RX_START: if (w_maj) r_state <= RX_IDLE;
                                RX_DATA:  r_shift <= {w_maj, r_shift[7:1]};
                                RX_STOP: begin
                                    // Decide on the stop sample; no wait for the bit end.
                                    r_state     <= w_maj ? RX_IDLE : RX_WAIT_HIGH;
                                    r_commit    <= w_maj;
                                    r_frame_err <= !w_maj;
                                end
                                default: ;
                            endcase
                        end
                        if (r_tick_cnt == T_LAST) begin
                            if (r_state == RX_START) begin
                                r_state <= RX_DATA;
                            end else if (r_state == RX_DATA) begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Holding register: a commit that meets a simultaneous transfer refills it;
    // a commit against a held, unaccepted byte is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_commit) begin
                if (!r_valid || rx_byte_ready) begin
                    r_byte  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_byte       = r_byte;
    assign rx_byte_valid = r_valid;
    assign frame_error   = r_frame_err;
    assign overrun_error = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at 50 MHz / 115200 baud (DIV=27,
// 432 clocks per bit). A negedge monitor logs transfers, error pulses and
// rx_byte stability; directed frames are checked against hand-computed values.
module tb_uart_rx;

    localparam int BIT_CLKS = 432;
    // Start edge driven after edge E0: 2 sync + 1 detect clocks, 153 ticks of
    // 27 clocks to the final stop sample, 1 clock to load -> E0 + 4135.
    localparam int LAT = 4135;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rx_byte_ready = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_error;
    logic       overrun_error;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int t_rise = 0;
    int n_fe = 0;
    int n_ovr = 0;
    int n_unstable = 0;
    logic [7:0] xq[$];
    logic       p_valid = 1'b0;
    logic       p_xfer = 1'b0;
    logic [7:0] p_byte = 8'h00;
    int fe0, ov0, q0;

    uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial     (rx_serial),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte_ready (rx_byte_ready),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_error) n_fe <= n_fe + 1;
            if (overrun_error) n_ovr <= n_ovr + 1;
            if (rx_byte_valid && rx_byte_ready) xq.push_back(rx_byte);
            if (rx_byte_valid && !p_valid) t_rise <= cyc;
            if (p_valid && !p_xfer && rx_byte != p_byte) n_unstable <= n_unstable + 1;
        end
        p_valid <= rx_byte_valid;
        p_xfer  <= rx_byte_valid && rx_byte_ready;
        p_byte  <= rx_byte;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] qat(input int k);
        return (xq.size() > k) ? xq[k] : 8'hxx;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        fe0 = n_fe;
        ov0 = n_ovr;
        q0  = xq.size();
    endtask

    // gl: cycle offset of a one-clock inverted glitch (-1 none)
    // ab: cycle offset at which the frame is abandoned (-1 none)
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int gl, input int ab);
        logic [9:0] f;
        f = {stop_b, d, 1'b0};
        for (int c = 0; c < 10 * BIT_CLKS; c++) begin
            if (c == ab) return;
            @(posedge clk);
            #1;
            if (c == 0) t0 = cyc;
            rx_serial = f[c / BIT_CLKS] ^ (c == gl);
        end
    endtask

    initial begin
        #5 rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_byte", rx_byte, 8'h00);
        chk("rst_valid", rx_byte_valid, 1'b0);
        chk("rst_fe", frame_error, 1'b0);
        chk("rst_ovr", overrun_error, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(20);

        // back-to-back 0xAA, 0x55
        snap();
        rx_byte_ready = 1'b1;
        send_frame(8'hAA, 1'b1, -1, -1);
        chk("latency", t_rise - t0, LAT);
        send_frame(8'h55, 1'b1, -1, -1);
        idle(50);
        chk("b2b_cnt", xq.size() - q0, 2);
        chk("b2b_0", qat(q0), 8'hAA);
        chk("b2b_1", qat(q0 + 1), 8'h55);
        chk("b2b_fe", n_fe - fe0, 0);
        chk("b2b_ovr", n_ovr - ov0, 0);

        // 2 us (100 clk) glitch on idle line, then 0x3C
        snap();
        @(posedge clk);
        #1 rx_serial = 1'b0;
        idle(100);
        rx_serial = 1'b1;
        idle(1000);
        chk("glitch_cnt", xq.size() - q0, 0);
        chk("glitch_valid", rx_byte_valid, 1'b0);
        chk("glitch_fe", n_fe - fe0, 0);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(50);
        chk("glitch_next_cnt", xq.size() - q0, 1);
        chk("glitch_next", qat(q0), 8'h3C);

        // framing error on 0x3C, then 0x81
        snap();
        send_frame(8'h3C, 1'b0, -1, -1);
        rx_serial = 1'b1;
        idle(50);
        chk("frm_fe", n_fe - fe0, 1);
        chk("frm_cnt", xq.size() - q0, 0);
        send_frame(8'h81, 1'b1, -1, -1);
        idle(50);
        chk("frm_next_cnt", xq.size() - q0, 1);
        chk("frm_next", qat(q0), 8'h81);
        chk("frm_fe_once", n_fe - fe0, 1);

        // 0x00 with a high glitch on the centre sample of data bit 3
        snap();
        send_frame(8'h00, 1'b1, 1944, -1);
        idle(50);
        chk("maj_cnt", xq.size() - q0, 1);
        chk("maj_byte", qat(q0), 8'h00);
        chk("maj_fe", n_fe - fe0, 0);

        // overrun: 0xA5 held, 0x5A dropped
        snap();
        rx_byte_ready = 1'b0;
        send_frame(8'hA5, 1'b1, -1, -1);
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(50);
        chk("ovr_valid", rx_byte_valid, 1'b1);
        chk("ovr_byte", rx_byte, 8'hA5);
        chk("ovr_pulse", n_ovr - ov0, 1);
        chk("ovr_cnt", xq.size() - q0, 0);
        rx_byte_ready = 1'b1;
        idle(5);
        chk("ovr_xfer_cnt", xq.size() - q0, 1);
        chk("ovr_xfer", qat(q0), 8'hA5);
        chk("ovr_valid_fall", rx_byte_valid, 1'b0);

        // commit coinciding with a transfer of the held byte
        snap();
        rx_byte_ready = 1'b0;
        send_frame(8'h12, 1'b1, -1, -1);
        fork
            send_frame(8'h34, 1'b1, -1, -1);
            begin
                repeat (LAT) @(posedge clk);
                #1 rx_byte_ready = 1'b1;
            end
        join
        idle(50);
        chk("sim_cnt", xq.size() - q0, 2);
        chk("sim_0", qat(q0), 8'h12);
        chk("sim_1", qat(q0 + 1), 8'h34);
        chk("sim_ovr", n_ovr - ov0, 0);
        chk("sim_valid", rx_byte_valid, 1'b0);

        // reset during data bit 4 with 0x81 held
        snap();
        rx_byte_ready = 1'b0;
        send_frame(8'h81, 1'b1, -1, -1);
        idle(50);
        chk("pre_rst_valid", rx_byte_valid, 1'b1);
        chk("pre_rst_byte", rx_byte, 8'h81);
        send_frame(8'h0F, 1'b1, -1, 2300);
        @(posedge clk);
        #1 rst_n = 1'b0;
        idle(5);
        @(negedge clk);
        chk("mid_rst_byte", rx_byte, 8'h00);
        chk("mid_rst_valid", rx_byte_valid, 1'b0);
        chk("mid_rst_fe", frame_error, 1'b0);
        chk("mid_rst_ovr", overrun_error, 1'b0);
        rx_serial = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(20);
        chk("post_rst_valid", rx_byte_valid, 1'b0);
        rx_byte_ready = 1'b1;
        send_frame(8'h7E, 1'b1, -1, -1);
        idle(50);
        chk("post_rst_cnt", xq.size() - q0, 1);
        chk("post_rst_byte", qat(q0), 8'h7E);
        chk("post_rst_fe", n_fe - fe0, 0);

        chk("byte_stable", n_unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, >=8).
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have port rx_serial, input, 1 bit, asynchronous UART line, idle high.
REQ-007 The block SHALL have port rx_byte, output, 8 bits, received data byte.
REQ-008 The block SHALL have port rx_byte_valid, output, 1 bit, rx_byte holds an unconsumed byte.
REQ-009 The block SHALL have port rx_byte_ready, input, 1 bit, downstream accepts the byte; transfer occurs when valid and ready are both high on a clock edge.
REQ-010 The block SHALL have port frame_error, output, 1 bit, one-cycle pulse when the stop bit samples low.
REQ-011 The block SHALL have port overrun_error, output, 1 bit, one-cycle pulse when a completed byte is dropped.

Function
REQ-012 rx_serial SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized signal.
REQ-013 Tick generator SHALL pulse one cycle every DIV clocks, where DIV = round(CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE)), minimum 1.
- The tick counter SHALL restart at 0 when a start edge is detected, so bit timing is phase-aligned to the edge.
REQ-014 State machine SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: when the synchronized line is 0, the FSM SHALL go to START and clear the tick and bit counters.
REQ-016 Bit value SHALL be the majority of 3 samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-017 START: if the start-bit majority is 1, the FSM SHALL return to IDLE (false start, no outputs); otherwise it SHALL go to DATA after tick OVERSAMPLE-1.
REQ-018 DATA: the FSM SHALL shift in 8 bits LSB first; after bit 7 ends it SHALL go to STOP.
REQ-019 STOP, majority 1: the FSM SHALL commit the byte on the clock after the third sample and then go to IDLE.
- The FSM does not wait for the end of the stop bit.
REQ-020 STOP, majority 0: the FSM SHALL discard the byte, pulse frame_error, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL go to IDLE once the synchronized line is 1.
REQ-022 Output SHALL be a one-entry holding register; commit loads rx_byte and sets rx_byte_valid.
- rx_byte_valid falls after a transfer and stays high until one occurs.
REQ-023 rx_byte SHALL be stable while rx_byte_valid is high and no transfer has occurred.
REQ-024 Commit while valid=1 and ready=0: the new byte SHALL be dropped, the held byte kept, and overrun_error pulsed.
REQ-025 Commit while valid=1 and ready=1 in the same cycle: the old byte SHALL transfer, the new byte SHALL load, valid SHALL stay 1, and no overrun occurs.
REQ-026 Latency SHALL be: rx_byte_valid rises 1 clk after the final stop sample, about 9.56 bit times plus 2-3 clk after the start edge.

Reset
REQ-027 While rst_n=0 the block SHALL hold: FSM in IDLE; counters 0; shift register 0; rx_byte=0x00; rx_byte_valid=0; frame_error=0; overrun_error=0; synchronizer=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no partial byte delivered.
- After release, a low line is treated as a new start edge.

Structure
REQ-029 Package uart_pkg SHALL hold the rx state enum and a function computing DIV from CLK_FREQ_HZ, BAUD_RATE and OVERSAMPLE.
- The packet handler's TX side and the future uart_tx reuse this function.
REQ-030 Tick generation SHALL be a sub-module uart_baud_tick_gen.
- It has a sync clear input and a tick output; rx instantiates it with the OVERSAMPLE rate.

Verification
REQ-031 Back-to-back frames: CLK 50 MHz, 115200 baud, DIV=27; send 0xAA then 0x55 with ready=1 -> two valid pulses in order, rx_byte=0xAA then 0x55, no error pulses.
REQ-032 Glitch: 2 us low pulse on idle line -> FSM returns to IDLE, no rx_byte_valid, no errors; a following frame 0x3C is received correctly.
REQ-033 Framing: send 0x3C with stop bit 0 -> frame_error single pulse, no rx_byte_valid; the next valid frame 0x81 is received as 0x81.
REQ-034 Overrun: ready=0, send 0xA5 then 0x5A -> valid stays high with 0xA5, overrun_error pulses once; raise ready -> one transfer of 0xA5, valid falls.
REQ-035 Majority vote: frame 0x00 with a 1-clk high glitch on the center sample of bit 3 -> received 0x00.
REQ-036 Reset: assert rst_n=0 at bit 4 of a frame, release, then send 0x7E -> only 0x7E is delivered, and all outputs were at reset values during reset.
